// File: rtl/load_store_unit.sv
// Load/store unit: sequences one bus access per start_i pulse, packs store lanes and extracts load lanes.
// Optional MISALIGN_CHECK_EN rejects misaligned half/word accesses without touching the bus.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        bus_err_o,
  output logic        misaligned_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              unsigned_q, unsigned_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              done_q, done_d;
  logic              bus_err_q, bus_err_d;
  logic              misaligned_q, misaligned_d;

  logic [1:0]        size_eff;
  logic              is_mem_op;
  logic              misalign_in;
  logic [31:0]       rd_ext;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  assign size_eff  = (size_i == 2'd3) ? 2'd2 : size_i;
  assign is_mem_op = is_load_i | is_store_i;

`ifdef MISALIGN_CHECK_EN
  assign misalign_in = ((size_eff == 2'd1) && addr_i[0]) ||
                       ((size_eff == 2'd2) && (addr_i[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  always_comb begin
    rd_byte = 8'h00;
    case (lane_q)
      2'd0: rd_byte = mem_rdata_i[7:0];
      2'd1: rd_byte = mem_rdata_i[15:8];
      2'd2: rd_byte = mem_rdata_i[23:16];
      default: rd_byte = mem_rdata_i[31:24];
    endcase
    rd_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      2'd0:    rd_ext = {{24{rd_byte[7] & ~unsigned_q}}, rd_byte};
      2'd1:    rd_ext = {{16{rd_half[15] & ~unsigned_q}}, rd_half};
      default: rd_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    lane_d       = lane_q;
    unsigned_d   = unsigned_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    done_d       = 1'b0;
    bus_err_d    = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && is_mem_op && !misalign_in) begin
          state_d     = S_ACCESS;
          cnt_d       = '0;
          size_d      = size_eff;
          lane_d      = addr_i[1:0];
          unsigned_d  = unsigned_i;
          mem_req_d   = 1'b1;
          mem_we_d    = is_store_i;
          mem_addr_d  = {addr_i[31:2], 2'b00};
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0;
          if (is_store_i) begin
            case (size_eff)
              2'd0: begin
                mem_wstrb_d = 4'b0001 << addr_i[1:0];
                mem_wdata_d = {4{store_data_i[7:0]}};
              end
              2'd1: begin
                mem_wstrb_d = addr_i[1] ? 4'b1100 : 4'b0011;
                mem_wdata_d = {2{store_data_i[15:0]}};
              end
              default: begin
                mem_wstrb_d = 4'b1111;
                mem_wdata_d = store_data_i;
              end
            endcase
          end
        end else if (start_i) begin
          // Non-memory op or rejected misaligned access: report completion immediately.
          state_d      = S_DONE;
          done_d       = 1'b1;
          misaligned_d = misalign_in & is_mem_op;
          load_data_d  = 32'h0;
        end
      end
      S_ACCESS: begin
        if (mem_ack_i) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          done_d      = 1'b1;
          load_data_d = mem_we_q ? 32'h0 : rd_ext;
        end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d     = S_DONE;
          cnt_d       = cnt_q + CNT_W'(1);
          mem_req_d   = 1'b0;
          done_d      = 1'b1;
          bus_err_d   = 1'b1;
          load_data_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      size_q       <= 2'd0;
      lane_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      load_data_q  <= 32'h0;
      done_q       <= 1'b0;
      bus_err_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      unsigned_q   <= unsigned_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      done_q       <= done_d;
      bus_err_q    <= bus_err_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign stall_o      = (state_q == S_IDLE && start_i && is_mem_op) || (state_q == S_ACCESS);
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wstrb_o  = mem_wstrb_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign load_data_o  = load_data_q;
  assign done_o       = done_q;
  assign bus_err_o    = bus_err_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit in its default build (misalignment check disabled).
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        is_load_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [1:0]  size_i = 2'd0;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] store_data_i = 32'h0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic [31:0] load_data_o;
  logic        done_o, stall_o, bus_err_o, misaligned_o;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .is_load_i(is_load_i), .is_store_i(is_store_i),
    .size_i(size_i), .unsigned_i(unsigned_i),
    .addr_i(addr_i), .store_data_i(store_data_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .load_data_o(load_data_o), .done_o(done_o), .stall_o(stall_o),
    .bus_err_o(bus_err_o), .misaligned_o(misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a one-cycle start pulse; returns just after the capturing edge.
  task automatic start_op(input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] sd);
    start_i = 1'b1; is_load_i = ld; is_store_i = st; size_i = sz;
    unsigned_i = uns; addr_i = a; store_data_i = sd;
    step();
    start_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
  endtask

  task automatic ack_with(input logic [31:0] rd);
    mem_ack_i = 1'b1; mem_rdata_i = rd;
    step();
    mem_ack_i = 1'b0;
  endtask

  initial begin
    logic early_done;
    step(); step();
    rst_i = 1'b0;
    chk("rst_outs", {22'd0, mem_req_o, mem_we_o, mem_wstrb_o, done_o, bus_err_o, misaligned_o, stall_o},
        32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    chk("rst_ldata", load_data_o, 32'h0);

    // LB, ack in first ACCESS cycle
    start_i = 1'b1; is_load_i = 1'b1; size_i = 2'd0; unsigned_i = 1'b0; addr_i = 32'h1003;
    #1 chk("lb_stall_idle", {31'd0, stall_o}, 32'd1);
    step();
    start_i = 1'b0; is_load_i = 1'b0;
    chk("lb_req", {31'd0, mem_req_o}, 32'd1);
    chk("lb_addr", mem_addr_o, 32'h1000);
    chk("lb_wstrb", {28'd0, mem_wstrb_o}, 32'h0);
    chk("lb_we", {31'd0, mem_we_o}, 32'd0);
    chk("lb_done_early", {31'd0, done_o}, 32'd0);
    ack_with(32'h80FF_1234);
    chk("lb_done", {31'd0, done_o}, 32'd1);
    chk("lb_data", load_data_o, 32'hFFFF_FF80);
    chk("lb_req_drop", {31'd0, mem_req_o}, 32'd0);
    step();
    chk("lb_done_1cyc", {31'd0, done_o}, 32'd0);
    chk("lb_data_hold", load_data_o, 32'hFFFF_FF80);

    // LHU / LH upper half
    start_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h2002, 32'h0);
    ack_with(32'hBEEF_0000);
    chk("lhu_data", load_data_o, 32'h0000_BEEF);
    step();
    start_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0);
    ack_with(32'hBEEF_0000);
    chk("lh_data", load_data_o, 32'hFFFF_BEEF);
    step();

    // SB
    start_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h3001, 32'h0000_00A5);
    chk("sb_wstrb", {28'd0, mem_wstrb_o}, 32'h2);
    chk("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
    chk("sb_addr", mem_addr_o, 32'h3000);
    chk("sb_we", {31'd0, mem_we_o}, 32'd1);
    ack_with(32'h0);
    chk("sb_done", {31'd0, done_o}, 32'd1);
    step();

    // SH, with an ignored start pulse while in ACCESS
    start_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h3002, 32'h0000_1234);
    chk("sh_wstrb", {28'd0, mem_wstrb_o}, 32'hC);
    chk("sh_wdata", mem_wdata_o, 32'h1234_1234);
    start_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h9000, 32'h0);
    chk("busy_start_addr", mem_addr_o, 32'h3000);
    chk("busy_start_req", {31'd0, mem_req_o, mem_we_o}, 32'd3);
    ack_with(32'h0);
    chk("sh_done", {31'd0, done_o}, 32'd1);
    step();

    // SW at 0x4002 without misalign check proceeds as full word
    start_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h4002, 32'hCAFE_F00D);
    chk("sw_wstrb", {28'd0, mem_wstrb_o}, 32'hF);
    chk("sw_addr", mem_addr_o, 32'h4000);
    chk("sw_wdata", mem_wdata_o, 32'hCAFE_F00D);
    ack_with(32'h0);
    chk("sw_misal", {31'd0, misaligned_o}, 32'd0);
    step();

    // size 3 behaves as word load
    start_op(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0);
    ack_with(32'hDEAD_BEEF);
    chk("size3_data", load_data_o, 32'hDEAD_BEEF);
    step();

    // Non-memory op goes straight to DONE
    start_i = 1'b1; addr_i = 32'h0;
    #1 chk("nop_stall", {31'd0, stall_o}, 32'd0);
    step();
    start_i = 1'b0;
    chk("nop_done", {31'd0, done_o, mem_req_o}, 32'd2);
    chk("nop_data", load_data_o, 32'h0);
    step();

    // Timeout: 16 ACCESS cycles without ack
    start_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h5000, 32'h0);
    early_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done_o || !mem_req_o) early_done = 1'b1;
      step();
    end
    chk("to_no_early_done", {31'd0, early_done}, 32'd0);
    chk("to_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("to_done", {31'd0, done_o}, 32'd1);
    chk("to_bus_err", {31'd0, bus_err_o}, 32'd1);
    chk("to_data", load_data_o, 32'h0);
    chk("to_req_low", {31'd0, mem_req_o}, 32'd0);
    step();
    chk("to_after", {30'd0, done_o, bus_err_o}, 32'd0);
    chk("to_req_after", {31'd0, mem_req_o}, 32'd0);

    // Reset in 3rd ACCESS cycle, then late ack
    start_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h6000, 32'h0);
    step(); step();
    chk("rst_mid_req", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    step();
    rst_i = 1'b0;
    chk("rst_mid_done", {31'd0, done_o}, 32'd0);
    step();
    mem_ack_i = 1'b0;
    chk("rst_mid_outs", {22'd0, mem_req_o, mem_we_o, mem_wstrb_o, done_o, bus_err_o, misaligned_o, stall_o},
        32'h0);
    chk("rst_mid_addr", mem_addr_o, 32'h0);
    chk("rst_mid_ldata", load_data_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, number of ACCESS cycles without mem_ack_i before a bus error.
REQ-002 SHALL have port: clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start_i  in  1  one-cycle pulse from execute requesting a memory operation.
REQ-005 SHALL have ports: is_load_i  in  1 / is_store_i  in  1  operation kind; sampled with start_i.
REQ-006 SHALL have ports: size_i  in  2  (0 byte, 1 half, 2 word) / unsigned_i  in  1  zero-extend loads.
REQ-007 SHALL have ports: addr_i  in  32  effective address (execute address_o) / store_data_i  in  32  rs2 value.
REQ-008 SHALL have ports: mem_req_o  out  1 / mem_we_o  out  1 / mem_addr_o  out  32  word-aligned address / mem_wstrb_o  out  4 / mem_wdata_o  out  32.
REQ-009 SHALL have ports: mem_ack_i  in  1 / mem_rdata_i  in  32.
REQ-010 SHALL have ports: load_data_o  out  32 / done_o  out  1 / stall_o  out  1 / bus_err_o  out  1 / misaligned_o  out  1.

Function
REQ-011 SHALL implement FSM IDLE, ACCESS, DONE; all outputs except stall_o registered.
REQ-012 IDLE + start_i + (is_load_i or is_store_i) SHALL capture all inputs, clear timeout counter, go to ACCESS; mem_req_o high from next cycle.
REQ-013 IDLE + start_i with neither load nor store SHALL go to DONE with no bus request.
REQ-014 start_i outside IDLE SHALL be ignored.
REQ-015 In ACCESS, mem_req_o and all mem_* outputs SHALL hold stable until the cycle mem_ack_i is sampled high.
REQ-016 mem_ack_i high in ACCESS SHALL go to DONE; mem_req_o low the following cycle; minimum start-to-done latency 2 cycles (ack in first ACCESS cycle).
REQ-017 Timeout counter SHALL increment each ACCESS cycle without ack; reaching TIMEOUT_CYCLES SHALL go to DONE with bus_err_o=1 and load_data_o=0.
REQ-018 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE; bus_err_o/misaligned_o valid only with done_o.
REQ-019 load_data_o SHALL be updated on entry to DONE and held until next DONE.
REQ-020 mem_addr_o SHALL be {addr[31:2],2'b00}; mem_we_o = is_store.
REQ-021 Store byte: wstrb = 1<<addr[1:0], wdata = byte replicated x4; half: wstrb 0011 (addr[1]=0) / 1100, wdata = half replicated x2; word: 1111, full data.
REQ-022 Loads SHALL drive wstrb 0000; result byte/half selected by addr[1:0]/addr[1], sign-extended unless unsigned_i; word unmodified.
REQ-023 stall_o SHALL be combinational: (IDLE and start_i and (is_load_i or is_store_i)) or state==ACCESS.
REQ-024 size_i=3 SHALL be treated as word.

Reset
REQ-025 rst_i high SHALL force IDLE next edge, including mid-ACCESS (request dropped, no done_o).
REQ-026 Reset values: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wstrb_o=0, mem_wdata_o=0, load_data_o=0, done_o=0, bus_err_o=0, misaligned_o=0, counter=0.
REQ-027 rst_i SHALL take priority over start_i and mem_ack_i in the same cycle.

Configuration
REQ-028 Macro MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go directly to DONE with misaligned_o=1, no bus request, load_data_o=0.
REQ-029 MISALIGN_CHECK_EN undefined: misaligned_o SHALL be tied 0; low address bits not needed for lane selection ignored and access proceeds.

Verification
REQ-030 LB addr=0x1003, mem_rdata=0x80FF_1234, ack 1st ACCESS cycle -> done_o at start+2, load_data_o=0xFFFF_FF80.
REQ-031 LHU addr=0x2002, rdata=0xBEEF_0000 -> load_data_o=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-032 SB addr=0x3001 data=0x0000_00A5 -> mem_wstrb_o=0010, mem_wdata_o=0xA5A5_A5A5, mem_addr_o=0x3000; SH addr=0x3002 -> wstrb 1100.
REQ-033 LW, ack never asserted, TIMEOUT_CYCLES=16 -> done_o with bus_err_o=1 after 16 ACCESS cycles, mem_req_o low afterwards.
REQ-034 SW addr=0x4002 with MISALIGN_CHECK_EN -> no mem_req_o, done_o next cycle, misaligned_o=1; without macro -> wstrb 1111 at 0x4000.
REQ-035 rst_i asserted on 3rd ACCESS cycle, then late mem_ack_i -> IDLE, no done_o, all outputs at reset values.
